// File: rtl/tohost_pkg.sv
// Shared definitions for the tohost monitor: FSM state encoding and protocol constants.
package tohost_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_PASS,
        ST_FAIL,
        ST_TIMEOUT
    } state_t;

    // riscv-tests convention: writing 1 to tohost signals a passing test
    localparam int TOHOST_PASS_VAL = 1;

    function automatic logic isTerminal(input state_t s);
        return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
    endfunction

endpackage

// File: rtl/tohost_con_fifo.sv
// Small synchronous byte FIFO for the console channel. A push into a full FIFO
// is dropped and latches a sticky overflow flag, unless a pop frees a slot in
// the same cycle, in which case both happen.
module tohost_con_fifo
    import tohost_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [7:0] i_data,
    input  logic       i_ready,
    output logic       o_valid,
    output logic [7:0] o_data,
    output logic       o_overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [PW-1:0] r_rdPtr;
    logic [PW-1:0] r_wrPtr;
    logic [PW:0] r_count;
    logic        r_overflow;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;

    // Occupancy decode and the accepted push/pop strobes for this cycle
    always_comb begin
        w_empty = (r_count == '0);
        w_full  = (r_count == FULL_COUNT);
        w_pop   = !w_empty && i_ready;
        w_push  = i_push && (!w_full || w_pop);
    end

    // Storage, wrapping pointers, occupancy count and sticky overflow
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_rdPtr    <= '0;
            r_wrPtr    <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wrPtr] <= i_data;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid    = !w_empty;
    assign o_data     = r_mem[r_rdPtr];
    assign o_overflow = r_overflow;

endmodule

// File: rtl/tohost_monitor.sv
// Snoops the CPU data-memory write port, decodes the riscv-tests tohost
// protocol (1 = pass, other nonzero = fail with code value>>1), runs a
// watchdog and buffers console bytes. The tohost decision is taken on the
// same edge that captures the write, so flags appear one cycle after the
// write is presented and a write wins over a watchdog expiry on that edge.
module tohost_monitor
    import tohost_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int DATA_WIDTH     = 32,
    parameter int TOHOST_ADDR    = 16384,
    parameter int CONSOLE_ADDR   = 16388,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int CNT_WIDTH      = 32,
    parameter int CON_DEPTH      = 4,
    parameter int LED_DIV        = 24
) (
    input  logic                    sysclk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mem_wr_en,
    input  logic [ADDR_WIDTH-1:0]   mem_wr_addr,
    input  logic [DATA_WIDTH-1:0]   mem_wr_data,
    input  logic [DATA_WIDTH/8-1:0] mem_wr_strb,
    output logic                    done,
    output logic                    pass,
    output logic                    fail,
    output logic                    timeout,
    output logic [DATA_WIDTH-2:0]   fail_code,
    output logic [CNT_WIDTH-1:0]    cycle_count,
    output logic                    con_valid,
    output logic [7:0]              con_data,
    input  logic                    con_ready,
    output logic                    con_overflow,
    output logic                    led
);

    localparam int SW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] TOHOST_A  = ADDR_WIDTH'(TOHOST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] CONSOLE_A = ADDR_WIDTH'(CONSOLE_ADDR);
    localparam logic [CNT_WIDTH-1:0]  TIMEOUT_C = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] PASS_V    = DATA_WIDTH'(TOHOST_PASS_VAL);

    state_t                r_state;
    state_t                w_nextState;
    logic [DATA_WIDTH-1:0] r_shadow;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [DATA_WIDTH-2:0] r_failCode;
    logic [CNT_WIDTH-1:0]  r_cycleCount;
    logic [CNT_WIDTH-1:0]  w_countNext;
    logic [LED_DIV-1:0]    r_ledDiv;
    logic                  r_led;
    logic                  w_ledNext;
    logic                  w_tohostWr;
    logic                  w_consoleWr;
    logic                  w_timeoutHit;
    logic                  w_unusedAddrBits;

    // Byte offset within a word is irrelevant to the word-address match
    assign w_unusedAddrBits = ^mem_wr_addr[1:0];

    // Address decode, byte-strobe merge into the tohost shadow, saturating count
    always_comb begin
        w_tohostWr  = mem_wr_en && (mem_wr_addr[ADDR_WIDTH-1:2] == TOHOST_A[ADDR_WIDTH-1:2]);
        w_consoleWr = mem_wr_en && (mem_wr_addr[ADDR_WIDTH-1:2] == CONSOLE_A[ADDR_WIDTH-1:2])
                      && mem_wr_strb[0];
        w_merged = r_shadow;
        for (int i = 0; i < SW; i++) begin
            if (mem_wr_strb[i]) begin
                w_merged[8*i +: 8] = mem_wr_data[8*i +: 8];
            end
        end
        w_countNext  = (&r_cycleCount) ? r_cycleCount : r_cycleCount + CNT_WIDTH'(1);
        w_timeoutHit = (TIMEOUT_CYCLES != 0) && (w_countNext == TIMEOUT_C);
    end

    // Next-state and next-LED logic; tohost verdict takes priority over the watchdog
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_tohostWr && (w_merged == PASS_V)) begin
                    w_nextState = ST_PASS;
                end else if (w_tohostWr && (w_merged != '0)) begin
                    w_nextState = ST_FAIL;
                end else if (w_timeoutHit) begin
                    w_nextState = ST_TIMEOUT;
                end
            end
            default: w_nextState = r_state;
        endcase

        w_ledNext = 1'b0;
        if (w_nextState == ST_PASS) begin
            w_ledNext = 1'b1;
        end else if ((w_nextState == ST_RUN) && (r_state == ST_RUN)) begin
            w_ledNext = (&r_ledDiv) ? ~r_led : r_led;
        end
    end

    // FSM state register; terminal states hold until reset
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // RUN-cycle counter, LED divider, tohost shadow, fail code and LED register
    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_cycleCount <= '0;
            r_ledDiv     <= '0;
            r_shadow     <= '0;
            r_failCode   <= '0;
            r_led        <= 1'b0;
        end else begin
            if (r_state == ST_RUN) begin
                r_cycleCount <= w_countNext;
                r_ledDiv     <= r_ledDiv + 1'b1;
                if (w_tohostWr) begin
                    r_shadow <= w_merged;
                end
                if (w_nextState == ST_FAIL) begin
                    r_failCode <= w_merged[DATA_WIDTH-1:1];
                end
            end
            r_led <= w_ledNext;
        end
    end

    tohost_con_fifo #(
        .DEPTH(CON_DEPTH)
    ) u_conFifo (
        .i_clk      (sysclk),
        .i_rst      (rst),
        .i_push     (w_consoleWr),
        .i_data     (mem_wr_data[7:0]),
        .i_ready    (con_ready),
        .o_valid    (con_valid),
        .o_data     (con_data),
        .o_overflow (con_overflow)
    );

    assign done        = isTerminal(r_state);
    assign pass        = (r_state == ST_PASS);
    assign fail        = (r_state == ST_FAIL);
    assign timeout     = (r_state == ST_TIMEOUT);
    assign fail_code   = r_failCode;
    assign cycle_count = r_cycleCount;
    assign led         = r_led;

endmodule
